// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the pipelined immediate generator.
//   fmt_e     : 3-bit immediate format code.
//   OP_*      : RV32/RV64 major opcodes recognised by the decoder.
//   imm_res_t : decoded result held in the output and skid registers. The
//               fields are sized for the widest datapath; narrower configs
//               use the low XLEN bits.
package imm_gen_pkg;

    localparam int unsigned XLEN_MAX = 64;
    localparam int unsigned INST_W   = 32;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        logic [XLEN_MAX-1:0] target;
        fmt_e                fmt;
        logic                illegal;
    } imm_res_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bus of the immediate generator.
//   in_valid/in_ready/in_inst/in_pc          : instruction input channel.
//   out_valid/out_ready/out_imm/out_target/
//   out_fmt/out_illegal                      : decoded result channel.
//   master : the side that issues instructions and consumes results.
//   slave  : the immediate generator itself.
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN = 32
);
    import imm_gen_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;
    logic [XLEN-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_imm;
    logic [XLEN-1:0]   out_target;
    fmt_e              out_fmt;
    logic              out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_target, out_fmt, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_target, out_fmt, out_illegal
    );

endinterface

// File: rtl/imm_gen_pipe_extract.sv
// Combinational immediate extraction: (instruction, pc) -> imm_res_t.
//   i_inst : raw 32-bit instruction.
//   i_pc   : PC of i_inst.
//   o_res  : immediate, pc-relative target, format code and illegal flag.
module imm_extract
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INST_W-1:0] i_inst,
    input  logic [XLEN-1:0]   i_pc,
    output imm_res_t          o_res
);

    logic [6:0]      w_opcode;
    fmt_e            w_fmt;
    logic            w_rel;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_target;
    logic            w_unused_funct3;

    assign w_opcode        = i_inst[6:0];
    assign w_unused_funct3 = ^i_inst[13:12];

    // Opcode to format. Every recognised opcode ends in 2'b11, so compressed
    // encodings fall through to FMT_NONE.
    always_comb begin
        w_fmt = FMT_NONE;
        w_rel = 1'b0;
        case (w_opcode)
            OP_LOAD, OP_IMM, OP_JALR: w_fmt = FMT_I;
            OP_IMM32:  w_fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
            OP_SYSTEM: w_fmt = i_inst[14] ? FMT_Z : FMT_I;
            OP_STORE:  w_fmt = FMT_S;
            OP_BRANCH: begin w_fmt = FMT_B; w_rel = 1'b1; end
            OP_LUI:    w_fmt = FMT_U;
            OP_AUIPC:  begin w_fmt = FMT_U; w_rel = 1'b1; end
            OP_JAL:    begin w_fmt = FMT_J; w_rel = 1'b1; end
            default:   ;
        endcase
    end

    // 32-bit immediate; Z is zero-extended here, so the later sign extension
    // to XLEN leaves it positive.
    always_comb begin
        w_imm32 = '0;
        case (w_fmt)
            FMT_I:   w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            FMT_Z:   w_imm32 = {27'd0, i_inst[19:15]};
            FMT_S:   w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            FMT_B:   w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                                i_inst[30:25], i_inst[11:8], 1'b0};
            FMT_U:   w_imm32 = {i_inst[31:12], 12'd0};
            FMT_J:   w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                                i_inst[20], i_inst[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign w_imm    = XLEN'($signed(w_imm32));
    assign w_target = w_rel ? (i_pc + w_imm) : '0;

    assign o_res.imm     = XLEN_MAX'(w_imm);
    assign o_res.target  = XLEN_MAX'(w_target);
    assign o_res.fmt     = w_fmt;
    assign o_res.illegal = (w_fmt == FMT_NONE);

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: one decoded result per handshake, one cycle
// after the input transfer, with an optional 2-entry skid buffer.
//   clk : clock, rising edge.
//   rst : synchronous active-high reset; drops every held item.
//   bus : imm_gen_pipe_if slave (input instruction channel, output result channel).
// SKID=1 gives a registered in_ready; SKID=0 uses in_ready = ~out_valid | out_ready.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter bit          SKID = 1'b1
) (
    input logic           clk,
    input logic           rst,
    imm_gen_pipe_if.slave bus
);

    imm_res_t w_res;
    imm_res_t r_out;
    imm_res_t r_skid;
    imm_res_t w_out_nxt;
    imm_res_t w_skid_nxt;
    logic     r_out_valid;
    logic     r_skid_valid;
    logic     r_in_ready;
    logic     w_out_valid_nxt;
    logic     w_skid_valid_nxt;
    logic     w_load_out;
    logic     w_in_ready;
    logic     w_in_fire;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .i_inst (bus.in_inst),
        .i_pc   (bus.in_pc),
        .o_res  (w_res)
    );

    // Output register can take a new item when empty or being drained.
    assign w_load_out = ~r_out_valid | bus.out_ready;
    assign w_in_ready = SKID ? r_in_ready : (~rst & w_load_out);
    assign w_in_fire  = bus.in_valid & w_in_ready;

    // Skid entry has priority over the input so order is preserved. With
    // SKID=0, in_ready equals w_load_out and the skid path is never entered.
    always_comb begin
        w_out_valid_nxt  = r_out_valid;
        w_out_nxt        = r_out;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_nxt       = r_skid;
        if (w_load_out) begin
            if (r_skid_valid) begin
                w_out_valid_nxt  = 1'b1;
                w_out_nxt        = r_skid;
                w_skid_valid_nxt = 1'b0;
            end else begin
                w_out_valid_nxt = w_in_fire;
                if (w_in_fire) begin
                    w_out_nxt = w_res;
                end
            end
        end else if (w_in_fire) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_nxt       = w_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out        <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
            r_in_ready   <= 1'b0;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_out        <= w_out_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid       <= w_skid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_imm     = r_out.imm[XLEN-1:0];
    assign bus.out_target  = r_out.target[XLEN-1:0];
    assign bus.out_fmt     = r_out.fmt;
    assign bus.out_illegal = r_out.illegal;

    // Upper halves of the shared struct are always zero on narrow datapaths.
    if (XLEN < XLEN_MAX) begin : g_pad
        logic w_unused_hi;
        assign w_unused_hi = ^{r_out.imm[XLEN_MAX-1:XLEN], r_out.target[XLEN_MAX-1:XLEN]};
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe: RV32/SKID=1 (a), RV64/SKID=1 (b),
// RV32/SKID=0 (c), all on one clock and reset.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    imm_gen_pipe_if #(.XLEN(32)) a ();
    imm_gen_pipe_if #(.XLEN(64)) b ();
    imm_gen_pipe_if #(.XLEN(32)) c ();

    imm_gen_pipe #(.XLEN(32), .SKID(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(a));
    imm_gen_pipe #(.XLEN(64), .SKID(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(b));
    imm_gen_pipe #(.XLEN(32), .SKID(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [31:0] inst, input logic [31:0] pc);
        chk("a_in_ready", 64'(a.in_ready), 64'd1);
        a.in_valid = 1'b1;
        a.in_inst  = inst;
        a.in_pc    = pc;
        @(posedge clk); #1;
        a.in_valid = 1'b0;
    endtask

    task automatic exp_a(input string tag, input logic [31:0] imm, input logic [31:0] tgt,
                         input logic [2:0] fmt, input logic ill);
        chk({tag, "_valid"},  64'(a.out_valid),   64'd1);
        chk({tag, "_imm"},    64'(a.out_imm),     64'(imm));
        chk({tag, "_target"}, 64'(a.out_target),  64'(tgt));
        chk({tag, "_fmt"},    64'(a.out_fmt),     64'(fmt));
        chk({tag, "_illegal"},64'(a.out_illegal), 64'(ill));
    endtask

    task automatic send_b(input logic [31:0] inst, input logic [63:0] pc);
        chk("b_in_ready", 64'(b.in_ready), 64'd1);
        b.in_valid = 1'b1;
        b.in_inst  = inst;
        b.in_pc    = pc;
        @(posedge clk); #1;
        b.in_valid = 1'b0;
    endtask

    task automatic exp_b(input string tag, input logic [63:0] imm, input logic [63:0] tgt,
                         input logic [2:0] fmt, input logic ill);
        chk({tag, "_valid"},  64'(b.out_valid),   64'd1);
        chk({tag, "_imm"},    b.out_imm,          imm);
        chk({tag, "_target"}, b.out_target,       tgt);
        chk({tag, "_fmt"},    64'(b.out_fmt),     64'(fmt));
        chk({tag, "_illegal"},64'(b.out_illegal), 64'(ill));
    endtask

    // addi x1, x0, 16*(k+1)
    function automatic logic [31:0] mk_addi(input int k);
        logic [11:0] v;
        v = 12'(16 * (k + 1));
        return {v, 5'd0, 3'd0, 5'd1, 7'b0010011};
    endfunction

    int   exp_rdy [10] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    int   exp_ov  [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int   exp_idx [10] = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 0};
    int   n_in;
    logic acc;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        a.in_valid = 1'b1; a.in_inst = 32'h00100093; a.in_pc = 32'h0; a.out_ready = 1'b1;
        b.in_valid = 1'b0; b.in_inst = 32'h0;        b.in_pc = 64'h0; b.out_ready = 1'b1;
        c.in_valid = 1'b0; c.in_inst = 32'h0;        c.in_pc = 32'h0; c.out_ready = 1'b1;

        // Reset held 3 cycles with a valid input pending.
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_a_out_valid", 64'(a.out_valid), 64'd0);
            chk("rst_a_in_ready",  64'(a.in_ready),  64'd0);
            chk("rst_c_in_ready",  64'(c.in_ready),  64'd0);
        end
        rst = 1'b0;
        a.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_a_in_ready",  64'(a.in_ready),  64'd1);
        chk("post_rst_a_out_valid", 64'(a.out_valid), 64'd0);
        chk("post_rst_b_in_ready",  64'(b.in_ready),  64'd1);
        chk("post_rst_c_in_ready",  64'(c.in_ready),  64'd1);

        // SKID=0: combinational in_ready follows out_valid/out_ready.
        c.out_ready = 1'b0;
        c.in_valid  = 1'b1; c.in_inst = 32'hFE000EE3; c.in_pc = 32'h100;
        @(posedge clk); #1;
        c.in_valid = 1'b0;
        chk("c_out_valid",  64'(c.out_valid),  64'd1);
        chk("c_imm",        64'(c.out_imm),    64'hFFFFFFFC);
        chk("c_target",     64'(c.out_target), 64'h000000FC);
        chk("c_stall_rdy",  64'(c.in_ready),   64'd0);
        c.out_ready = 1'b1;
        #1;
        chk("c_drain_rdy",  64'(c.in_ready),   64'd1);
        @(posedge clk); #1;
        chk("c_empty",      64'(c.out_valid),  64'd0);

        // RV32 decode vectors.
        send_a(32'hFE000EE3, 32'h100); exp_a("a_beq",     32'hFFFFFFFC, 32'h000000FC, 3'd3, 1'b0);
        send_a(32'hFE000EE3, 32'h0);   exp_a("a_beq_wrap",32'hFFFFFFFC, 32'hFFFFFFFC, 3'd3, 1'b0);
        send_a(32'hFE112E23, 32'h40);  exp_a("a_sw",      32'hFFFFFFFC, 32'h0,        3'd2, 1'b0);
        send_a(32'h12345037, 32'h40);  exp_a("a_lui",     32'h12345000, 32'h0,        3'd4, 1'b0);
        send_a(32'h0080006F, 32'h200); exp_a("a_jal",     32'h00000008, 32'h00000208, 3'd5, 1'b0);
        send_a(32'hFFF00093, 32'h40);  exp_a("a_addi",    32'hFFFFFFFF, 32'h0,        3'd1, 1'b0);
        send_a(32'h300FD073, 32'h40);  exp_a("a_csrrwi",  32'h0000001F, 32'h0,        3'd6, 1'b0);
        send_a(32'h00000000, 32'h40);  exp_a("a_zero",    32'h0,        32'h0,        3'd0, 1'b1);
        send_a(32'h0000001B, 32'h40);  exp_a("a_op32",    32'h0,        32'h0,        3'd0, 1'b1);

        // RV64 decode vectors.
        send_b(32'h80000017, 64'h1000);
        exp_b("b_auipc", 64'hFFFFFFFF80000000, 64'hFFFFFFFF80001000, 3'd4, 1'b0);
        send_b(32'h0000001B, 64'h1000);
        exp_b("b_op32",  64'h0, 64'h0, 3'd1, 1'b0);
        send_b(32'h300FD073, 64'h1000);
        exp_b("b_csrrwi",64'h1F, 64'h0, 3'd6, 1'b0);
        send_b(32'hFE000EE3, 64'h0);
        exp_b("b_beq_wrap", 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);

        @(posedge clk); #1;
        chk("a_idle", 64'(a.out_valid), 64'd0);

        // Skid: 6 items, out_ready low for the first 3 cycles.
        n_in = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            a.out_ready = (cyc >= 3);
            a.in_valid  = (n_in < 6);
            a.in_inst   = mk_addi(n_in);
            a.in_pc     = 32'h0;
            chk($sformatf("skid_rdy_c%0d", cyc), 64'(a.in_ready),  64'(exp_rdy[cyc]));
            chk($sformatf("skid_ov_c%0d", cyc),  64'(a.out_valid), 64'(exp_ov[cyc]));
            if (exp_ov[cyc] != 0)
                chk($sformatf("skid_imm_c%0d", cyc), 64'(a.out_imm),
                    64'(16 * (exp_idx[cyc] + 1)));
            acc = a.in_valid & a.in_ready;
            @(posedge clk); #1;
            if (acc) n_in++;
        end
        a.in_valid = 1'b0;
        chk("skid_accepted", 64'(n_in), 64'd6);

        // Reset while two items are held.
        a.out_ready = 1'b0;
        a.in_valid = 1'b1; a.in_inst = mk_addi(10);
        @(posedge clk); #1;
        a.in_inst = mk_addi(11);
        @(posedge clk); #1;
        a.in_valid = 1'b0;
        chk("hold_rdy", 64'(a.in_ready),  64'd0);
        chk("hold_ov",  64'(a.out_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ov",  64'(a.out_valid), 64'd0);
        chk("midrst_rdy", 64'(a.in_ready),  64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("after_rst_rdy", 64'(a.in_ready), 64'd1);
        a.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("no_stale_%0d", i), 64'(a.out_valid), 64'd0);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
